// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-outstanding memory port between instruction
// fetch and data load/store requesters.
//
// Ports
//   clk, rstn                     clock, asynchronous active-low reset
//   i_IReq_1/i_IAddr_32           fetch request and word address
//   o_IGnt_1                      fetch command accepted (one-cycle pulse)
//   o_IRvalid_1/o_IRdata_32       fetch response
//   i_DReq_1/i_DWe_1/i_DAddr_32/
//   i_DWdata_32/i_DBe_4           data request (load or store)
//   o_DGnt_1                      data command accepted (one-cycle pulse)
//   o_DRvalid_1/o_DRdata_32       load data or store acknowledge
//   o_MReq_1/o_MWe_1/o_MAddr_32/
//   o_MWdata_32/o_MBe_4           memory command
//   i_MGnt_1                      memory accepted the command
//   i_MRvalid_1/i_MRdata_32       memory response
//   i_Flush_1                     redirect, cancels fetch traffic
//   o_Stall_1                     pipeline hold request
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_IReq_1,
  input  logic [31:0] i_IAddr_32,
  output logic        o_IGnt_1,
  output logic        o_IRvalid_1,
  output logic [31:0] o_IRdata_32,
  input  logic        i_DReq_1,
  input  logic        i_DWe_1,
  input  logic [31:0] i_DAddr_32,
  input  logic [31:0] i_DWdata_32,
  input  logic [3:0]  i_DBe_4,
  output logic        o_DGnt_1,
  output logic        o_DRvalid_1,
  output logic [31:0] o_DRdata_32,
  output logic        o_MReq_1,
  output logic        o_MWe_1,
  output logic [31:0] o_MAddr_32,
  output logic [31:0] o_MWdata_32,
  output logic [3:0]  o_MBe_4,
  input  logic        i_MGnt_1,
  input  logic        i_MRvalid_1,
  input  logic [31:0] i_MRdata_32,
  input  logic        i_Flush_1,
  output logic        o_Stall_1
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_q, state_d;
  logic        owner_fetch_q;
  logic        drop_q;
  logic [2:0]  starve_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;

  logic        resp_cycle;
  logic        arb_cycle;
  logic        ireq_eff;
  logic        starved;
  logic        gnt_i;
  logic        gnt_d;
  logic        irvalid;
  logic        drvalid;

  // Arbitration happens in IDLE and in the response cycle of WAIT, so a
  // pending request is issued back-to-back. Gating with rstn keeps the
  // combinational grants and stall quiet while reset is held.
  assign resp_cycle = (state_q == WAIT) && i_MRvalid_1;
  assign arb_cycle  = rstn && ((state_q == IDLE) || resp_cycle);
  assign ireq_eff   = i_IReq_1 && !i_Flush_1;
  assign starved    = (starve_q == 3'(STARVE_MAX));
  assign gnt_d      = arb_cycle && i_DReq_1 && !(ireq_eff && starved);
  assign gnt_i      = arb_cycle && ireq_eff && !gnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (gnt_i || gnt_d) state_d = REQ;
      REQ: begin
        if (i_MGnt_1)                       state_d = WAIT;
        else if (i_Flush_1 && owner_fetch_q) state_d = IDLE;
      end
      WAIT: if (i_MRvalid_1) state_d = (gnt_i || gnt_d) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    irvalid     = resp_cycle && owner_fetch_q && !drop_q && !i_Flush_1;
    drvalid     = resp_cycle && !owner_fetch_q;
    o_IGnt_1    = gnt_i;
    o_DGnt_1    = gnt_d;
    o_IRvalid_1 = irvalid;
    o_DRvalid_1 = drvalid;
    o_IRdata_32 = irvalid ? i_MRdata_32 : '0;
    o_DRdata_32 = drvalid ? i_MRdata_32 : '0;
    o_MReq_1    = (state_q == REQ);
    o_MWe_1     = (state_q == REQ) && we_q;
    o_MAddr_32  = addr_q;
    o_MWdata_32 = wdata_q;
    o_MBe_4     = be_q;
    o_Stall_1   = rstn && ((i_IReq_1 && !irvalid) || (i_DReq_1 && !drvalid));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_fetch_q <= 1'b0;
      drop_q        <= 1'b0;
      starve_q      <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      we_q          <= 1'b0;
    end else begin
      if (gnt_i || gnt_d) begin
        owner_fetch_q <= gnt_i;
        addr_q        <= gnt_i ? i_IAddr_32 : i_DAddr_32;
        wdata_q       <= gnt_i ? '0 : i_DWdata_32;
        be_q          <= gnt_i ? '1 : i_DBe_4;
        we_q          <= gnt_d && i_DWe_1;
      end
      // A fetch already accepted by memory cannot be recalled; remember to
      // swallow its response instead.
      if (resp_cycle)
        drop_q <= 1'b0;
      else if (i_Flush_1 && owner_fetch_q &&
               ((state_q == WAIT) || ((state_q == REQ) && i_MGnt_1)))
        drop_q <= 1'b1;
      if (!i_IReq_1 || gnt_i)
        starve_q <= '0;
      else if (gnt_d && !starved)
        starve_q <= starve_q + 3'd1;
    end
  end

endmodule
